// File: rtl/blink_pkg.sv
// Shared definitions for the blink LED pattern sequencer: FSM state encoding
// and default sizing constants.
package blink_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int BLINK_TICK_DIV = 100000;
    localparam int BLINK_STEPS    = 16;
    localparam int BLINK_DUR_W    = 8;
    localparam int BLINK_REP_W    = 8;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick_o every TICK_DIV cycles while clr_i is low.
// clr_i holds the count at zero and suppresses the tick.
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] presc_q;

    assign tick_o = !clr_i && (presc_q == LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            presc_q <= '0;
        end else if (clr_i || tick_o) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + W'(1);
        end
    end

endmodule

// File: rtl/blink_seq_ctrl.sv
// LED pattern sequencer: plays a STEPS-bit pattern for a number of repeats, one step per (dur+1) ticks.
// Optional BLINK_SEQ_QUEUE_EN adds a one-entry pending command slot loaded back-to-back on finish.
module blink_seq_ctrl
    import blink_pkg::*;
#(
    parameter int TICK_DIV = BLINK_TICK_DIV,
    parameter int STEPS    = BLINK_STEPS,
    parameter int DUR_W    = BLINK_DUR_W,
    parameter int REP_W    = BLINK_REP_W
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [STEPS-1:0]         cmd_pattern_i,
    input  logic [$clog2(STEPS)-1:0] cmd_last_i,
    input  logic [DUR_W-1:0]         cmd_dur_i,
    input  logic [REP_W-1:0]         cmd_rep_i,
    input  logic                     abort_i,
    output logic                     led_o,
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int SW = $clog2(STEPS);

    state_e            state_q;
    logic [STEPS-1:0]  pat_q;
    logic [SW-1:0]     last_q, step_q, step_d;
    logic [DUR_W-1:0]  dur_q, dur_cnt_q, dur_cnt_d;
    logic [REP_W-1:0]  rep_q, rep_cnt_q, rep_cnt_d;
    logic              led_q, busy_q, done_q;

    logic              tick, accept, step_end, pat_end, finish, reload;
    logic [STEPS-1:0]  ld_pat;
    logic [SW-1:0]     ld_last;
    logic [DUR_W-1:0]  ld_dur;
    logic [REP_W-1:0]  ld_rep;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (state_q != ST_RUN),
        .tick_o  (tick)
    );

`ifdef BLINK_SEQ_QUEUE_EN
    logic              slot_vld_q;
    logic [STEPS-1:0]  slot_pat_q;
    logic [SW-1:0]     slot_last_q;
    logic [DUR_W-1:0]  slot_dur_q;
    logic [REP_W-1:0]  slot_rep_q;

    assign cmd_ready_o = rst_n_i && !abort_i && ((state_q == ST_IDLE) || !slot_vld_q);
    assign reload      = slot_vld_q || accept;
    assign ld_pat      = slot_vld_q ? slot_pat_q  : cmd_pattern_i;
    assign ld_last     = slot_vld_q ? slot_last_q : cmd_last_i;
    assign ld_dur      = slot_vld_q ? slot_dur_q  : cmd_dur_i;
    assign ld_rep      = slot_vld_q ? slot_rep_q  : cmd_rep_i;
`else
    assign cmd_ready_o = rst_n_i && !abort_i && (state_q == ST_IDLE);
    assign reload      = 1'b0;
    assign ld_pat      = cmd_pattern_i;
    assign ld_last     = cmd_last_i;
    assign ld_dur      = cmd_dur_i;
    assign ld_rep      = cmd_rep_i;
`endif

    assign accept   = cmd_valid_i && cmd_ready_o;
    assign step_end = tick && (dur_cnt_q == dur_q);
    assign pat_end  = step_end && (step_q == last_q);
    // rep==0 plays forever, so the repeat counter is only compared in finite mode
    assign finish   = pat_end && (rep_q != '0) && ((rep_cnt_q + REP_W'(1)) == rep_q);

    assign dur_cnt_d = step_end ? '0 : (tick ? dur_cnt_q + DUR_W'(1) : dur_cnt_q);
    assign step_d    = pat_end ? '0 : (step_end ? step_q + SW'(1) : step_q);
    assign rep_cnt_d = pat_end ? rep_cnt_q + REP_W'(1) : rep_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            last_q    <= '0;
            dur_q     <= '0;
            rep_q     <= '0;
            step_q    <= '0;
            dur_cnt_q <= '0;
            rep_cnt_q <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BLINK_SEQ_QUEUE_EN
            slot_vld_q  <= 1'b0;
            slot_pat_q  <= '0;
            slot_last_q <= '0;
            slot_dur_q  <= '0;
            slot_rep_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q   <= ST_RUN;
                        pat_q     <= cmd_pattern_i;
                        last_q    <= cmd_last_i;
                        dur_q     <= cmd_dur_i;
                        rep_q     <= cmd_rep_i;
                        step_q    <= '0;
                        dur_cnt_q <= '0;
                        rep_cnt_q <= '0;
                        led_q     <= cmd_pattern_i[0];
                        busy_q    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort_i) begin
                        state_q <= ST_IDLE;
                        led_q   <= 1'b0;
                        busy_q  <= 1'b0;
`ifdef BLINK_SEQ_QUEUE_EN
                        slot_vld_q <= 1'b0;
`endif
                    end else if (finish) begin
                        done_q    <= 1'b1;
                        step_q    <= '0;
                        dur_cnt_q <= '0;
                        rep_cnt_q <= '0;
                        if (reload) begin
                            // back-to-back: stay in RUN with the queued pattern
                            pat_q  <= ld_pat;
                            last_q <= ld_last;
                            dur_q  <= ld_dur;
                            rep_q  <= ld_rep;
                            led_q  <= ld_pat[0];
`ifdef BLINK_SEQ_QUEUE_EN
                            slot_vld_q <= 1'b0;
`endif
                        end else begin
                            state_q <= ST_IDLE;
                            led_q   <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        step_q    <= step_d;
                        dur_cnt_q <= dur_cnt_d;
                        rep_cnt_q <= rep_cnt_d;
                        led_q     <= pat_q[step_d];
`ifdef BLINK_SEQ_QUEUE_EN
                        if (accept) begin
                            slot_vld_q  <= 1'b1;
                            slot_pat_q  <= cmd_pattern_i;
                            slot_last_q <= cmd_last_i;
                            slot_dur_q  <= cmd_dur_i;
                            slot_rep_q  <= cmd_rep_i;
                        end
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    led_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign led_o  = led_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_blink_seq_ctrl.sv
// Directed bench for blink_seq_ctrl with a segment-based timeline model checked every cycle.
module tb_blink_seq_ctrl;
    localparam int TD = 4;
`ifdef BLINK_SEQ_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cmd_pattern = '0;
    logic [3:0]  cmd_last = '0;
    logic [7:0]  cmd_dur = '0;
    logic [7:0]  cmd_rep = '0;
    logic        cmd_ready, led, busy, done;

    always #5 clk = ~clk;

    blink_seq_ctrl #(.TICK_DIV(TD), .STEPS(16), .DUR_W(8), .REP_W(8)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_pattern_i (cmd_pattern),
        .cmd_last_i    (cmd_last),
        .cmd_dur_i     (cmd_dur),
        .cmd_rep_i     (cmd_rep),
        .abort_i       (abort),
        .led_o         (led),
        .busy_o        (busy),
        .done_o        (done)
    );

    int errors = 0, checks = 0, ecnt = 0;
    bit chk_en = 1'b0;
    int busy_cnt = 0, done_cnt = 0, led_hi_cnt = 0, last_done_edge = -1;

    // Model: each accepted command is a segment on the edge timeline. Period e is the
    // interval after rising edge e; offset k=e-start selects step (k/steplen)%(last+1).
    int          nseg = 0;
    int          kill = 32'h7fffffff;
    int          seg_acc[2], seg_start[2], seg_len[2], seg_last[2], seg_dur[2];
    logic [15:0] seg_pat[2];

    always @(posedge clk) ecnt++;

    function automatic void model_at(input int e, output logic m_led, output logic m_busy,
                                     output logic m_done, output logic m_pend);
        int k, steplen;
        m_led = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_pend = 1'b0;
        for (int s = 0; s < nseg; s++) begin
            if (e >= kill) continue;
            k = e - seg_start[s];
            if (e >= seg_acc[s] && k < 0) m_pend = 1'b1;
            if (k < 0) continue;
            steplen = (seg_dur[s] + 1) * TD;
            if (seg_len[s] == 0 || k < seg_len[s]) begin
                m_busy = 1'b1;
                m_led  = seg_pat[s][(k / steplen) % (seg_last[s] + 1)];
            end else if (k == seg_len[s]) begin
                m_done = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%b want=%b", name, ecnt, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic m_led, m_busy, m_done, m_pend, m_rdy;
        if (chk_en) begin
            model_at(ecnt, m_led, m_busy, m_done, m_pend);
            m_rdy = rst_n && !abort && (!m_busy || (QUEUE && !m_pend));
            chk("led", led, m_led);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("ready", cmd_ready, m_rdy);
            busy_cnt   += int'(busy);
            done_cnt   += int'(done);
            led_hi_cnt += int'(led);
            if (done === 1'b1) last_done_edge = ecnt;
        end
    end

    task automatic clear_cnt();
        busy_cnt = 0; done_cnt = 0; led_hi_cnt = 0; last_done_edge = -1;
    endtask

    // Called in a period right after #1 past a rising edge; returns at the same point one edge later.
    task automatic send(input logic [15:0] p, input int l, input int d, input int r, output int acc);
        logic ml, mb, md, mp;
        int s;
        model_at(ecnt, ml, mb, md, mp);
        if (!mb) begin
            nseg = 0;
            kill = 32'h7fffffff;
        end
        s = nseg;
        acc = ecnt + 1;
        seg_acc[s]   = acc;
        seg_start[s] = (s == 0) ? acc : seg_start[0] + seg_len[0];
        seg_len[s]   = (r == 0) ? 0 : (l + 1) * (d + 1) * TD * r;
        seg_pat[s]   = p;
        seg_last[s]  = l;
        seg_dur[s]   = d;
        nseg++;
        cmd_pattern = p;
        cmd_last    = 4'(l);
        cmd_dur     = 8'(d);
        cmd_rep     = 8'(r);
        cmd_valid   = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n0, n1;
        wait_cyc(2);
        @(negedge clk);
        chk("rst_led", led, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", cmd_ready, 1'b0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // basic playback
        clear_cnt();
        send(16'h0005, 3, 0, 1, n0);
        wait_cyc(24);
        chk_int("t1_busy_cycles", busy_cnt, 16);
        chk_int("t1_done_pulses", done_cnt, 1);
        chk_int("t1_led_high", led_hi_cnt, 8);
        chk_int("t1_done_offset", last_done_edge - n0, 16);

        // repeats
        clear_cnt();
        send(16'h0005, 3, 0, 3, n0);
        wait_cyc(56);
        chk_int("t2_busy_cycles", busy_cnt, 48);
        chk_int("t2_done_pulses", done_cnt, 1);
        chk_int("t2_led_high", led_hi_cnt, 24);

        // infinite with abort 100 cycles after acceptance
        clear_cnt();
        send(16'h0005, 3, 0, 0, n0);
        wait_cyc(99);
        abort = 1'b1;
        kill  = ecnt + 1;
        @(negedge clk);
        chk("t3_ready_abort", cmd_ready, 1'b0);
        @(posedge clk); #1;
        abort = 1'b0;
        wait_cyc(20);
        chk_int("t3_busy_cycles", busy_cnt, 100);
        chk_int("t3_done_pulses", done_cnt, 0);
        chk_int("t3_led_high", led_hi_cnt, 52);

        // abort while idle only masks ready
        abort = 1'b1;
        wait_cyc(2);
        abort = 1'b0;
        wait_cyc(2);

`ifdef BLINK_SEQ_QUEUE_EN
        clear_cnt();
        send(16'h0005, 3, 0, 1, n0);
        wait_cyc(4);
        send(16'h0001, 0, 1, 1, n1);
        wait_cyc(30);
        chk_int("t4_busy_cycles", busy_cnt, 24);
        chk_int("t4_done_pulses", done_cnt, 2);
        chk_int("t4_led_high", led_hi_cnt, 16);
`endif

        // reset mid-run (with a pending command when the slot exists)
        send(16'h0005, 3, 0, 0, n0);
        wait_cyc(3);
        if (QUEUE) send(16'h0001, 0, 1, 1, n1);
        wait_cyc(17);
        rst_n = 1'b0;
        kill  = ecnt + 1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_cnt();
        @(negedge clk);
        chk("t5_ready_after", cmd_ready, 1'b1);
        wait_cyc(40);
        chk_int("t5_busy_after", busy_cnt, 0);
        chk_int("t5_done_after", done_cnt, 0);

        // maximum fields
        clear_cnt();
        send(16'hA5C3, 15, 255, 2, n0);
        wait_cyc(32780);
        chk_int("t6_busy_cycles", busy_cnt, 32768);
        chk_int("t6_done_pulses", done_cnt, 1);
        chk_int("t6_led_high", led_hi_cnt, 16384);
        chk_int("t6_done_offset", last_done_edge - n0, 32768);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
